// File: rtl/key_event_queue_if.sv
// Keyboard-write / CPU-read signal bundle for key_event_queue.
// The slave modport is the queue; the master modport is the keyboard and CPU side.
interface key_event_queue_if #(
  parameter int DEPTH = 8
) ();
  logic [15:0]              data_in;
  logic                     DE;
  logic                     DRW;
  logic                     service;
  logic                     clear_overflow;
  logic [15:0]              data_out;
  logic                     valid;
  logic                     irq;
  logic [1:0]               key_index;
  logic                     pressed;
  logic                     decode_ok;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport slave (
    input  data_in, DE, DRW, service, clear_overflow,
    output data_out, valid, irq, key_index, pressed, decode_ok, count, overflow
  );

  modport master (
    output data_in, DE, DRW, service, clear_overflow,
    input  data_out, valid, irq, key_index, pressed, decode_ok, count, overflow
  );
endinterface

// File: rtl/key_event_queue.sv
// Buffers keyboard event words in a small FIFO, presents the oldest one decoded
// to the CPU and pops it on a rising edge of service.
module key_event_queue #(
  parameter int DEPTH = 8
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  key_event_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [15:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count_q;
  logic          overflow_q;
  logic          prev_we, prev_service;
  logic [15:0]   prev_data;

  logic we, push_req, pop, full, do_push, drop, valid_int;

  // A held write counts again whenever the word changes; zero words never enter.
  assign we        = bus.DE & bus.DRW;
  assign push_req  = we && (!prev_we || bus.data_in != prev_data) && bus.data_in != 16'h0000;
  assign valid_int = count_q != '0;
  assign pop       = bus.service && !prev_service && valid_int;
  assign full      = count_q == FULL_CNT;
  assign do_push   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      prev_we      <= 1'b0;
      prev_service <= 1'b0;
      prev_data    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every edge-detect register samples the pre-edge values.
      prev_we      <= we;
      prev_service <= bus.service;
      prev_data    <= bus.data_in;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop)
        overflow_q <= 1'b1;
      else if (bus.clear_overflow)
        overflow_q <= 1'b0;
    end
  end

  // NOTE: storage is deliberately left out of reset; count gates every read, so stale words are never visible.
  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem[wr_ptr] <= bus.data_in;
  end

  logic [15:0] head;
  logic [3:0]  nib;
  logic        release_ev;
  logic        one_hot;
  logic [1:0]  idx;

  assign head       = valid_int ? mem[rd_ptr] : 16'h0000;
  assign release_ev = |head[7:4];
  assign nib        = release_ev ? head[7:4] : head[3:0];
  assign one_hot    = (nib != 4'h0) && ((nib & (nib - 4'h1)) == 4'h0);

  // NOTE: idx gets a default first so this process can never infer a latch.
  always_comb begin
    idx = 2'd0;
    if      (nib[0]) idx = 2'd0;
    else if (nib[1]) idx = 2'd1;
    else if (nib[2]) idx = 2'd2;
    else if (nib[3]) idx = 2'd3;
  end

  assign bus.data_out  = head;
  assign bus.valid     = valid_int;
  assign bus.irq       = valid_int;
  assign bus.key_index = idx;
  assign bus.pressed   = valid_int && !release_ev;
  assign bus.decode_ok = valid_int && one_hot && (head[15:8] == 8'h00);
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_key_event_queue.sv
// Directed self-checking bench for key_event_queue (DEPTH=8); inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_key_event_queue;
  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  key_event_queue_if #(.DEPTH(8)) bus ();
  key_event_queue #(.DEPTH(8)) dut (.CLOCK_50(CLOCK_50), .resetn(resetn), .bus(bus));

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle_bus();
    bus.DE = 1'b0; bus.DRW = 1'b0; bus.data_in = 16'h0000;
  endtask

  task automatic push_one(input logic [15:0] w);
    bus.DE = 1'b1; bus.DRW = 1'b1; bus.data_in = w;
    step();
    idle_bus();
  endtask

  task automatic pop_one();
    bus.service = 1'b1; step();
    bus.service = 1'b0; step();
  endtask

  task automatic check_head(input string tag, input logic [15:0] w, input logic [1:0] k,
                            input logic p, input logic ok);
    check({tag, ".data"}, 32'(bus.data_out), 32'(w));
    check({tag, ".key"},  32'(bus.key_index), 32'(k));
    check({tag, ".prs"},  32'(bus.pressed), 32'(p));
    check({tag, ".ok"},   32'(bus.decode_ok), 32'(ok));
  endtask

  logic [15:0] fill_words [9] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008,
                                  16'h0010, 16'h0020, 16'h0040, 16'h0080, 16'h0011};

  initial begin
    idle_bus();
    bus.service = 1'b0; bus.clear_overflow = 1'b0;
    step(); step();
    check("rst.count", 32'(bus.count), 0);
    check("rst.valid", 32'(bus.valid), 0);
    check("rst.irq", 32'(bus.irq), 0);
    check("rst.ovf", 32'(bus.overflow), 0);
    check_head("rst", 16'h0000, 2'd0, 1'b0, 1'b0);
    resetn = 1'b1;
    step();

    // Single event held for three cycles pushes once
    bus.DE = 1'b1; bus.DRW = 1'b1; bus.data_in = 16'h0002;
    step(); step(); step();
    idle_bus();
    step();
    check("single.count", 32'(bus.count), 1);
    check("single.irq", 32'(bus.irq), 1);
    check_head("single", 16'h0002, 2'd1, 1'b1, 1'b1);
    bus.service = 1'b1; step();
    check("single.pop.count", 32'(bus.count), 0);
    check("single.pop.irq", 32'(bus.irq), 0);
    bus.service = 1'b0; step();

    // Zero word and pop-while-empty are both ignored
    push_one(16'h0000);
    check("zero.count", 32'(bus.count), 0);
    pop_one();
    check("empty_pop.count", 32'(bus.count), 0);

    // Held enable, changing data
    bus.DE = 1'b1; bus.DRW = 1'b1;
    bus.data_in = 16'h0001; step();
    bus.data_in = 16'h0010; step();
    bus.data_in = 16'h0044; step();
    bus.data_in = 16'h0044; step();
    idle_bus();
    check("held.count", 32'(bus.count), 3);
    check_head("held0", 16'h0001, 2'd0, 1'b1, 1'b1);
    pop_one();
    check_head("held1", 16'h0010, 2'd0, 1'b0, 1'b1);
    pop_one();
    check_head("held2", 16'h0044, 2'd2, 1'b0, 1'b1);
    pop_one();
    check("held.empty", 32'(bus.count), 0);

    // Fill past full
    bus.DE = 1'b1; bus.DRW = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.data_in = fill_words[i]; step();
    end
    idle_bus(); step();
    check("full.count", 32'(bus.count), 8);
    check("full.ovf", 32'(bus.overflow), 1);
    bus.clear_overflow = 1'b1; step(); bus.clear_overflow = 1'b0;
    check("clr.ovf", 32'(bus.overflow), 0);
    // Drop and clear in the same cycle: set wins
    bus.clear_overflow = 1'b1; push_one(16'h0022); bus.clear_overflow = 1'b0;
    check("setwins.ovf", 32'(bus.overflow), 1);
    check("setwins.count", 32'(bus.count), 8);
    bus.clear_overflow = 1'b1; step(); bus.clear_overflow = 1'b0;
    // Push with pop while full
    bus.service = 1'b1; push_one(16'h0033); bus.service = 1'b0;
    check("fullpp.count", 32'(bus.count), 8);
    check("fullpp.ovf", 32'(bus.overflow), 0);
    step();
    for (int i = 1; i < 8; i++) begin
      check($sformatf("readback%0d", i), 32'(bus.data_out), 32'(fill_words[i]));
      pop_one();
    end
    check("readback.last", 32'(bus.data_out), 32'h0033);
    pop_one();
    check("readback.empty", 32'(bus.count), 0);

    // Push with service rising while empty: push only
    bus.service = 1'b1; push_one(16'h0004); bus.service = 1'b0;
    check("emptypp.count", 32'(bus.count), 1);
    check("emptypp.data", 32'(bus.data_out), 32'h0004);
    step();

    // Wrap: one word resident, 20 simultaneous push/pop cycles
    for (int i = 0; i < 20; i++) begin
      logic [15:0] w;
      w = 16'h1000 + 16'(i * 3 + 1);
      bus.service = 1'b1; push_one(w); bus.service = 1'b0;
      step();
      check($sformatf("wrap%0d.data", i), 32'(bus.data_out), 32'(w));
      check($sformatf("wrap%0d.count", i), 32'(bus.count), 1);
    end
    pop_one();
    check("wrap.empty", 32'(bus.count), 0);

    // Held service pops once
    push_one(16'h0008); push_one(16'h0080);
    bus.service = 1'b1; step(); step(); step();
    check("hold_svc.count", 32'(bus.count), 1);
    check("hold_svc.data", 32'(bus.data_out), 32'h0080);
    bus.service = 1'b0; step();
    pop_one();
    check("hold_svc.empty", 32'(bus.count), 0);

    // Decode corner cases
    push_one(16'h0003);
    check_head("dec03", 16'h0003, 2'd0, 1'b1, 1'b0);
    pop_one();
    push_one(16'h0100);
    check_head("dec100", 16'h0100, 2'd0, 1'b1, 1'b0);
    pop_one();
    push_one(16'h00C0);
    check_head("decC0", 16'h00C0, 2'd2, 1'b0, 1'b0);
    pop_one();

    // Asynchronous reset with three events queued
    push_one(16'h0001); push_one(16'h0002); push_one(16'h0004);
    check("prerst.count", 32'(bus.count), 3);
    bus.clear_overflow = 1'b0;
    resetn = 1'b0;
    #2;
    check("arst.count", 32'(bus.count), 0);
    check("arst.valid", 32'(bus.valid), 0);
    check("arst.irq", 32'(bus.irq), 0);
    check("arst.ovf", 32'(bus.overflow), 0);
    check("arst.data", 32'(bus.data_out), 0);
    step();
    resetn = 1'b1;
    step();
    check("postrst.count", 32'(bus.count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/key_event_queue.md
# key_event_queue

Bus-side responder for keyboard event writes. It captures each 16-bit event word driven on the keyboard's data/DE/DRW outputs and buffers it in a small FIFO. It presents the oldest event to the CPU along with decoded key index and press/release fields, and pops that event on a CPU service strobe. It sits between keyboard_input and the CPU I/O read path, and raises a level interrupt while events are pending.

## Interface
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2
- CLOCK_50  input  1  system clock; all state updates on its rising edge
- resetn  input  1  asynchronous, active-low reset
- data_in  input  16  event word from keyboard (data)
- DE  input  1  device enable from keyboard
- DRW  input  1  device read/write from keyboard; 1 = write
- service  input  1  CPU pop request; acts on its rising edge
- clear_overflow  input  1  synchronous clear of the overflow flag
- data_out  output  16  raw head-of-queue word; 0 when empty
- valid  output  1  queue non-empty
- irq  output  1  interrupt request; equals valid
- key_index  output  2  decoded key number of the head word
- pressed  output  1  1 = press event, 0 = release event
- decode_ok  output  1  head word decoded to exactly one key
- count  output  log2(DEPTH)+1  occupancy, 0..DEPTH
- overflow  output  1  sticky: an event was dropped because the queue was full

## Operation
- Write detect:
  - Registers prev_we and prev_data sample DE&DRW and data_in every cycle.
  - push = (DE&DRW) && (!prev_we || data_in != prev_data) && data_in != 0.
  - The keyboard holds DE/DRW high after its first event, so a change of data_in while the write is active counts as a new event.
  - Zero words are never stored.
- Pop detect: prev_service register; pop = service && !prev_service && count != 0. A pop while empty is ignored.
- FIFO: wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH. Memory is written at wr_ptr on push.
- Push and pop in the same cycle:
  - Both are performed and count is unchanged.
  - When full, the push is accepted because a slot frees that cycle.
  - When empty, only the push is performed.
- Push while full without a same-cycle pop: the word is dropped, pointers are unchanged, and overflow is set.
- overflow clears on clear_overflow=1. If clear_overflow and a drop occur in the same cycle, set wins.
- Decode (combinational from data_out):
  - If data_out[7:4] is nonzero: pressed=0 and the release nibble is decoded.
  - Otherwise: pressed=1 and data_out[3:0] is decoded.
  - key_index is the position of the set bit in the chosen nibble.
  - decode_ok=1 only when that nibble is one-hot and data_out[15:8]==0.
  - When decode_ok=0, key_index is the lowest set bit of the chosen nibble.
  - Example: 0x0044 decodes as a release of key 2 with decode_ok=1.
- When empty: data_out=0, key_index=0, pressed=0, decode_ok=0.

## Timing
- Reset (async assert, released synchronously by use):
  - wr_ptr, rd_ptr, count, overflow, prev_we, prev_service and prev_data all reset to 0.
  - Outputs: valid=0, irq=0, data_out=0, key_index=0, pressed=0, decode_ok=0, count=0, overflow=0.
  - Memory contents need no reset.
- Push latency: a write condition present before rising edge k is stored at edge k. valid, count and data_out (when the queue was empty) update immediately after edge k.
- Pop latency: a service rising edge sampled at edge k advances rd_ptr at edge k. The next word, or empty, is visible after edge k.
- Holding service high pops once only. The next pop requires service to return low for at least one cycle.
- Reset asserted mid-operation empties the queue immediately. Events in flight are lost.
- Throughput: one push and one pop per cycle maximum.

## Test plan
- Reset: assert resetn=0 mid-traffic with count=3 -> count=0, valid=0, irq=0, overflow=0, data_out=0 asynchronously.
- Single event: DE=DRW=1 with data_in=0x0002 for 3 cycles -> exactly one push; count=1, data_out=0x0002, key_index=1, pressed=1, decode_ok=1. Then pulse service -> count=0, irq=0.
- Held-enable sequence: DE/DRW stay high while data_in goes 0x0001→0x0010→0x0044→0x0044 -> 3 pushes. Successive pops show press key0; release key0; release key2 (key_index=2, pressed=0).
- Full/overflow: with DEPTH=8, push 9 distinct alternating words -> count=8, overflow=1, and the 9th word is absent on readback. clear_overflow -> overflow=0. The queue reads back 8 words in order.
- Simultaneous push/pop:
  - When full: count stays 8, overflow stays 0, and the new word appears last.
  - When empty with service rising: count=1 and the word is retained.
- Wrap and decode: 20 push/pop cycles wrap both pointers with data order preserved. data_in=0x0003 -> decode_ok=0, key_index=0, pressed=1. data_in=0x0100 -> decode_ok=0.
